// File: rtl/accel_reduce.sv
// accel_reduce: memory-mapped sequential reduction engine with GPIO
// and a 2-entry read-response buffer on the emesh fabric.
module accel_reduce #(
  parameter int          AW    = 32,
  parameter int          PW    = 2*AW+40,
  parameter logic [11:0] ID    = 12'h810,
  parameter logic [3:0]  GROUP = 4'hF,
  parameter int          RFAW  = 6,
  parameter int          N     = 4,
  parameter int          GW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          access_in,
  input  logic [PW-1:0] packet_in,
  output logic          wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  input  logic [GW-1:0] gpio_in,
  output logic [GW-1:0] gpio_out
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic          write;
  logic [31:0]   dstaddr;
  logic [AW-1:0] data;
  logic [AW-1:0] srcaddr;
  logic          unused_bits;

  assign write   = packet_in[0];
  assign dstaddr = packet_in[39:8];
  assign data    = packet_in[AW+39:40];
  assign srcaddr = packet_in[2*AW+39:AW+40];
  assign unused_bits = ^{packet_in[7:1], dstaddr};

  logic            busy, done;
  logic            accept, match;
  logic            wr, rd, start, last;
  logic [RFAW-1:0] off, oidx;
  logic            in_op;
  logic [2:0]      op;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   acc, acc_nxt, acc_init;
  logic [AW-1:0]   result, rdata;
  logic [AW-1:0]   operand [N];
  logic [GW-1:0]   gpio_q;

  logic [1:0]      count;
  logic            wptr, rptr, pop;
  logic [AW-1:0]   buf_data [2];
  logic [AW-1:0]   buf_src  [2];

  assign busy     = (state == RUN);
  assign wait_out = busy | (count == 2'd2);
  assign accept   = access_in & ~wait_out;
  assign match    = (dstaddr[31:20] == ID) &&
                    (dstaddr[19:16] == GROUP);
  assign wr       = accept & match & write;
  assign rd       = accept & match & ~write;
  assign off      = dstaddr[RFAW+1:2];
  assign oidx     = off - RFAW'(4);
  assign in_op    = (off >= RFAW'(4)) &&
                    (off < RFAW'(4+N));
  assign start    = wr && (off == '0) && data[8];
  assign last     = busy && (idx == IW'(N-1));
  assign acc_init = (data[2:0] == 3'd2 ||
                     data[2:0] == 3'd5) ? '1 : '0;
  assign gpio_out = gpio_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt = '0;
    unique case (op)
      3'd0: acc_nxt = acc + operand[idx];
      3'd1: acc_nxt = acc ^ operand[idx];
      3'd2: acc_nxt = acc & operand[idx];
      3'd3: acc_nxt = acc | operand[idx];
      3'd4: acc_nxt = (operand[idx] > acc) ?
                      operand[idx] : acc;
      3'd5: acc_nxt = (operand[idx] < acc) ?
                      operand[idx] : acc;
      default: acc_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= '0;
      done   <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      gpio_q <= '0;
      for (int i = 0; i < N; i++) operand[i] <= '0;
    end else begin
      if (wr && off == '0) begin
        op <= data[2:0];
        if (data[8]) begin
          acc  <= acc_init;
          idx  <= '0;
          done <= 1'b0;
        end
      end
      if (busy) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
        if (last) begin
          result <= acc_nxt;
          done   <= 1'b1;
        end
      end
      if (wr && off == RFAW'(2)) gpio_q <= data[GW-1:0];
      for (int i = 0; i < N; i++)
        if (wr && in_op && oidx == RFAW'(i))
          operand[i] <= data;
    end
  end

  // read data is captured in the accept cycle
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == RFAW'(0): rdata[1:0]    = {done, busy};
      off == RFAW'(1): rdata         = result;
      off == RFAW'(2): rdata[GW-1:0] = gpio_q;
      off == RFAW'(3): rdata[GW-1:0] = gpio_in;
      in_op:           rdata = operand[oidx[IW-1:0]];
      default:         rdata = '0;
    endcase
  end

  assign access_out = (count != 2'd0);
  assign pop        = access_out & ~wait_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_src[i]  <= '0;
      end
    end else begin
      if (rd) begin
        buf_data[wptr] <= rdata;
        buf_src[wptr]  <= srcaddr;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      unique case ({rd, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    packet_out = '0;
    if (access_out) begin
      packet_out[0]        = 1'b1;
      packet_out[2:1]      = 2'b10;
      packet_out[39:8]     = 32'(buf_src[rptr]);
      packet_out[AW+39:40] = buf_data[rptr];
    end
  end

endmodule

// File: doc/accel_reduce.md
# accel_reduce

Parametrised memory-mapped reduction accelerator on the emesh fabric. Holds N operand registers, a control/status register and GPIO registers. On a start command it reduces the operands sequentially under a selected operation. Read responses go through a 2-deep buffer that honours downstream wait, and each response returns the requester's srcaddr.

## Interface
- AW, 32, emesh address/data width
- PW, 2*AW+40, packet width
- ID, 12'h810, chip ID matched against dstaddr[31:20]
- GROUP, 4'hF, MMR group matched against dstaddr[19:16]
- RFAW, 6, register-file address width; word offset = dstaddr[RFAW+1:2]
- N, 4, operand register count (2..32)
- GW, 24, GPIO width (1..AW)

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- access_in  in  1  request valid
- packet_in  in  PW  request packet, decoded by packet2emesh
- wait_out  out  1  back-pressure to requester
- access_out  out  1  read-response valid
- packet_out  out  PW  read-response packet, built by emesh2packet
- wait_in  in  1  back-pressure from response consumer
- gpio_in  in  GW  sampled inputs
- gpio_out  out  GW  driven outputs

## Operation
- Accept: access_in & ~wait_out. Match: dstaddr[31:20]==ID and dstaddr[19:16]==GROUP. A non-matching access is consumed with no effect and no response.
- Word map (offset o):
  - 0 CTRL: write bits[2:0]=op; bit[8]=start. Read {bit1 done, bit0 busy}, other bits 0.
  - 1 RESULT: read-only.
  - 2 GPIO_OUT: read/write, low GW bits.
  - 3 GPIO_IN: read-only; returns gpio_in zero-extended.
  - 4..4+N-1 OPERAND[o-4]: read/write.
  - Unmapped offsets: writes ignored; reads return 0.
- Writes to read-only registers are ignored. Every accepted matching read produces exactly one response.
- Ops, with accumulator init:
  - 0 sum mod 2^AW (init 0)
  - 1 xor (init 0)
  - 2 and (init all-ones)
  - 3 or (init 0)
  - 4 unsigned max (init 0)
  - 5 unsigned min (init all-ones)
  - 6, 7: result 0
- FSM states:
  - IDLE: an accepted CTRL write with start=1 latches op, loads the accumulator init, idx=0, clears done, goes to RUN. A CTRL write with start=0 only updates the stored op.
  - RUN: each cycle acc = f(acc, OPERAND[idx]) and idx++. In the cycle with idx==N-1, RESULT gets the final value, done is set, and the FSM returns to IDLE.
- done is sticky until the next start.
- Response packet: write=1, datamode=2'b10, ctrlmode=0, dstaddr=request srcaddr, srcaddr=0, data=read value.
- Read values are sampled in the accept cycle.

## Timing
- wait_out = busy | (rr_count==2). It is registered-state only; there is no combinational path from access_in or wait_in.
- Start accepted in cycle t:
  - busy=1 in cycles t+1..t+N.
  - RESULT valid and done=1 from t+N+1.
  - wait_out is low again at t+N+1, provided the buffer is not full.
- Read accepted in cycle t: the entry is pushed at the end of t; access_out=1 from t+1.
- Pop happens when access_out & ~wait_in. packet_out holds stable while wait_in=1.
- Simultaneous push and pop keeps the count unchanged; buffer order is FIFO.
- When the buffer is full, wait_out stays high that cycle even if a pop occurs (conservative).
- Register writes take effect at the end of the accept cycle. A read in the next cycle returns the new value.
- Reset values: all outputs 0, access_out=0, wait_out=0, FSM=IDLE, buffer empty, operands/RESULT/GPIO_OUT/op/done=0.
- Reset asserted mid-RUN or with buffered responses: return to the reset state immediately; pending responses are discarded.

## Test plan
- Sum: write OPERAND0..3 = 1, 2, 3, 0xFFFFFFFF; CTRL=0x100. Required response: busy for exactly 4 cycles; RESULT read = 0x00000005 (wrap), with dstaddr equal to the request srcaddr.
- Min/max: operands 7, 0x80000000, 3, 9. Op 5 gives RESULT 3; op 4 gives 0x80000000. Status read after completion = 0x2.
- Back-pressure:
  - Hold wait_in=1 and issue 3 back-to-back reads of GPIO_IN with gpio_in=0xABCDEF.
  - Required: wait_out rises after 2 accepts and access_out stays 1 with a stable packet.
  - Release wait_in: 3 responses of 0x00ABCDEF in order; none lost or duplicated.
- Busy stall: issue a write to OPERAND0 during RUN. Required: wait_out=1 until the run ends; the write lands afterwards; RESULT reflects the old value.
- Decode: a read with ID=0x811 gives no response. A read of offset 4+N gives data 0. A write to RESULT leaves it unchanged. GPIO_OUT write of 0xFFFFFFFF gives gpio_out = all-ones over GW bits.
- Reset: assert reset at RUN cycle 2 with one response buffered. Required: access_out=0, busy=0 and done=0 immediately; a subsequent RESULT read returns 0.
